// File: rtl/text_box_writer.sv
// Typewriter-style dialog writer: maps ASCII to glyph indices and fills a COLS x ROWS cell RAM.
// Optional macro TEXT_SKIP_EN lets an advance_in rising edge cut short the per-glyph delay.
module text_box_writer #(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int CHAR_DELAY = 1000000
) (
    input  logic                            pixel_clk_in,
    input  logic                            rst_in,
    input  logic [7:0]                      char_in,
    input  logic                            char_valid_in,
    output logic                            char_ready_out,
    input  logic                            advance_in,
    output logic                            cell_we_out,
    output logic [$clog2(COLS*ROWS)-1:0]    cell_addr_out,
    output logic [5:0]                      cell_data_out,
    output logic                            busy_out,
    output logic                            page_full_out
);

    // state      | meaning
    // S_IDLE     | waiting for a character (ready high)
    // S_WRITE    | glyph strobe cycle, or one-cycle gap for a newline
    // S_DELAY    | typewriter gap after a written glyph
    // S_PAGE_FULL| page exhausted, waiting for advance_in rising edge
    // S_CLEAR    | blanking every cell in ascending address order

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW    = (CHAR_DELAY > 1) ? $clog2(CHAR_DELAY) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(CELLS - 1);
    localparam logic [DW-1:0] DELAY_LOAD = DW'(CHAR_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DELAY,
        S_PAGE_FULL,
        S_CLEAR
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            wrapped;
    logic            page_done;
    logic [DW-1:0]   delay_cnt;
    logic            adv_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [5:0]      data_q;

    logic            adv_rise;
    logic            delay_done;
    logic            is_newline;
    logic [AW-1:0]   cursor_addr;

    function automatic logic [5:0] glyph_of(input logic [7:0] c);
        logic [5:0] g;
        g = 6'd0;
        if (c >= 8'h41 && c <= 8'h5A)      g = 6'(c - 8'h40);
        else if (c >= 8'h61 && c <= 8'h7A) g = 6'(c - 8'h60);
        else if (c >= 8'h30 && c <= 8'h39) g = 6'(c - 8'h15);
        else if (c == 8'h21)               g = 6'd37;
        else if (c == 8'h2E)               g = 6'd38;
        else if (c == 8'h3F)               g = 6'd39;
        return g;
    endfunction

    assign adv_rise    = advance_in & ~adv_q;
    assign is_newline  = (char_in == 8'h0A);
    assign cursor_addr = AW'(int'(row) * COLS + int'(col));

`ifdef TEXT_SKIP_EN
    assign delay_done = (delay_cnt == '0) || adv_rise;
`else
    assign delay_done = (delay_cnt == '0);
`endif

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            wrapped   <= 1'b0;
            page_done <= 1'b0;
            delay_cnt <= '0;
            adv_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            adv_q <= advance_in;
            we_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (char_valid_in) begin
                        state <= S_WRITE;
                        if (is_newline) begin
                            // a newline right after an automatic wrap would only add a blank line
                            if (!(wrapped && col == '0 && row != '0)) begin
                                col <= '0;
                                if (row == ROW_LAST) page_done <= 1'b1;
                                else                 row <= row + RW'(1);
                            end
                            wrapped <= 1'b0;
                        end else begin
                            we_q   <= 1'b1;
                            addr_q <= cursor_addr;
                            data_q <= glyph_of(char_in);
                            if (col == COL_LAST) begin
                                col <= '0;
                                if (row == ROW_LAST) begin
                                    page_done <= 1'b1;
                                    wrapped   <= 1'b0;
                                end else begin
                                    row     <= row + RW'(1);
                                    wrapped <= 1'b1;
                                end
                            end else begin
                                col     <= col + CW'(1);
                                wrapped <= 1'b0;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    // we_q is high here only for a real glyph; newlines skip the delay
                    if (we_q && CHAR_DELAY != 0) begin
                        state     <= S_DELAY;
                        delay_cnt <= DELAY_LOAD;
                    end else begin
                        state <= page_done ? S_PAGE_FULL : S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (delay_done) begin
                        state     <= page_done ? S_PAGE_FULL : S_IDLE;
                        delay_cnt <= '0;
                    end else begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
                S_PAGE_FULL: begin
                    if (adv_rise) begin
                        state  <= S_CLEAR;
                        we_q   <= 1'b1;
                        addr_q <= '0;
                        data_q <= 6'd0;
                    end
                end
                S_CLEAR: begin
                    if (addr_q == ADDR_LAST) begin
                        state     <= S_IDLE;
                        row       <= '0;
                        col       <= '0;
                        wrapped   <= 1'b0;
                        page_done <= 1'b0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= addr_q + AW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign char_ready_out = (state == S_IDLE);
    assign busy_out       = (state != S_IDLE);
    assign page_full_out  = (state == S_PAGE_FULL);
    assign cell_we_out    = we_q;
    assign cell_addr_out  = addr_q;
    assign cell_data_out  = data_q;

endmodule

// File: tb/tb_text_box_writer.sv
// Scoreboard bench for text_box_writer: a cursor/page model queues expected cell writes,
// a negedge monitor checks every strobe; directed cases plus randomized dialog text.
module tb_text_box_writer;

    localparam int COLS       = 4;
    localparam int ROWS       = 2;
    localparam int CHAR_DELAY = 4;
    localparam int CELLS      = COLS * ROWS;
    localparam int AW         = $clog2(CELLS);

    logic          pixel_clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid_in = 1'b0;
    logic          char_ready_out;
    logic          advance_in = 1'b0;
    logic          cell_we_out;
    logic [AW-1:0] cell_addr_out;
    logic [5:0]    cell_data_out;
    logic          busy_out;
    logic          page_full_out;

    text_box_writer #(.COLS(COLS), .ROWS(ROWS), .CHAR_DELAY(CHAR_DELAY)) dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_in         (rst_in),
        .char_in        (char_in),
        .char_valid_in  (char_valid_in),
        .char_ready_out (char_ready_out),
        .advance_in     (advance_in),
        .cell_we_out    (cell_we_out),
        .cell_addr_out  (cell_addr_out),
        .cell_data_out  (cell_data_out),
        .busy_out       (busy_out),
        .page_full_out  (page_full_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  tests  = 0;
    int  failed = 0;

    // reference cursor: linear position on the page plus "just auto-wrapped" flag
    int  m_pos  = 0;
    bit  m_jw   = 0;
    bit  m_full = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_glyph(input logic [7:0] c);
        string      tbl;
        logic [7:0] u;
        tbl = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789!.?";
        u = c;
        if (u >= "a" && u <= "z") u = u - 8'd32;
        for (int i = 0; i < tbl.len(); i++)
            if (8'(tbl[i]) == u) return i + 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m_pos  = 0;
        m_jw   = 0;
        m_full = 0;
    endfunction

    always @(negedge pixel_clk_in) begin
        if (cell_we_out) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_strobe: got addr %0d data %0d, expected no write",
                         cell_addr_out, cell_data_out);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("strobe_addr", int'(cell_addr_out), e.addr);
                chk("strobe_data", int'(cell_data_out), e.data);
                chk("strobe_busy", int'(busy_out), 1);
            end
        end
    end

    task automatic apply_reset();
        rst_in        = 1'b1;
        char_valid_in = 1'b0;
        advance_in    = 1'b0;
        repeat (2) @(negedge pixel_clk_in);
        exp_q.delete();
        model_reset();
        chk("rst_we", int'(cell_we_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_page_full", int'(page_full_out), 0);
        chk("rst_addr", int'(cell_addr_out), 0);
        chk("rst_data", int'(cell_data_out), 0);
        rst_in = 1'b0;
        @(negedge pixel_clk_in);
        chk("rst_ready_after", int'(char_ready_out), 1);
    endtask

    // called at a negedge; pulse_at>0 raises advance_in at that many cycles after acceptance
    task automatic send_char(input logic [7:0] c, input int pulse_at, output int waited);
        bit printable;
        int exp_lat;
        int got;
        wr_t w;
        printable = (c != 8'h0A);
        if (printable) begin
            w.addr = m_pos;
            w.data = ref_glyph(c);
            exp_q.push_back(w);
            m_pos++;
            m_jw   = (m_pos % COLS == 0) && (m_pos < CELLS);
            m_full = (m_pos == CELLS);
        end else begin
            if (!m_jw) begin
                m_pos  = (m_pos / COLS + 1) * COLS;
                m_full = (m_pos >= CELLS);
            end
            m_jw = 0;
        end
        exp_lat = printable ? 2 + CHAR_DELAY : 2;
`ifdef TEXT_SKIP_EN
        if (printable && pulse_at >= 2 && pulse_at <= CHAR_DELAY + 1) exp_lat = pulse_at + 1;
`endif
        char_in       = c;
        char_valid_in = 1'b1;
        waited = 0;
        while (!char_ready_out && waited < 100) begin
            @(negedge pixel_clk_in);
            waited++;
        end
        if (waited >= 100) chk("accept_timeout", waited, 0);
        @(posedge pixel_clk_in);
        #1 char_valid_in = 1'b0;
        got = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge pixel_clk_in);
            if (pulse_at != 0 && k == pulse_at) advance_in = 1'b1;
            if (pulse_at != 0 && k == pulse_at + 1) advance_in = 1'b0;
            if (k == 1) chk("we_after_accept", int'(cell_we_out), int'(printable));
            if (k == 2) chk("we_one_cycle", int'(cell_we_out), 0);
            if (char_ready_out || page_full_out) begin
                got = k;
                break;
            end
        end
        if (pulse_at != 0) advance_in = 1'b0;
        chk("ready_latency", got, exp_lat);
        chk("page_full_state", int'(page_full_out), int'(m_full));
    endtask

    task automatic do_clear();
        wr_t w;
        int  got;
        for (int i = 0; i < CELLS; i++) begin
            w.addr = i;
            w.data = 0;
            exp_q.push_back(w);
        end
        model_reset();
        advance_in = 1'b1;
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge pixel_clk_in);
            if (k == 1) advance_in = 1'b0;
            if (char_ready_out) begin
                got = k;
                break;
            end
        end
        chk("clear_latency", got, CELLS + 1);
        chk("clear_all_written", exp_q.size(), 0);
    endtask

    task automatic send_str(input string s);
        int w;
        for (int i = 0; i < s.len(); i++) send_char(8'(s[i]), 0, w);
    endtask

    function automatic logic [7:0] rand_char();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 8'h0A;
        if (sel == 1) begin
            case ($urandom_range(0, 5))
                0: return "!";
                1: return ".";
                2: return "?";
                3: return " ";
                4: return "#";
                default: return "~";
            endcase
        end
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int got;

        apply_reset();
        send_char("H", 0, w);
        chk("accept_first_cycle", w, 0);

        apply_reset();
        send_str("AB");
        send_char(8'h0A, 0, w);
        send_char("c", 0, w);

        apply_reset();
        send_char("Q", 2, w);

        apply_reset();
        for (int i = 0; i < CELLS; i++) send_char(8'($urandom_range(65, 90)), 0, w);
        chk("full_ready_low", int'(char_ready_out), 0);
        do_clear();
        send_char("x", 0, w);

        // wrap then newline is swallowed; newline on last row fills the page
        apply_reset();
        send_str("ABCD");
        send_char(8'h0A, 0, w);
        send_char("E", 0, w);
        send_char(8'h0A, 0, w);
        do_clear();

        // advance held high before the page fills must not start a clear
        apply_reset();
        advance_in = 1'b1;
        send_str("12345678");
        repeat (5) @(negedge pixel_clk_in);
        chk("held_adv_page_full", int'(page_full_out), 1);
        advance_in = 1'b0;
        @(negedge pixel_clk_in);
        do_clear();

        // reset in the middle of a clear
        send_str("ZZZZZZZZ");
        for (int i = 0; i < CELLS; i++) exp_q.push_back('{addr: i, data: 0});
        advance_in = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pixel_clk_in);
            if (k == 1) advance_in = 1'b0;
            if (cell_we_out && cell_addr_out == AW'(3)) begin
                got = 1;
                break;
            end
        end
        chk("clear_reached_addr3", got, 1);
        rst_in = 1'b1;
        @(posedge pixel_clk_in);
        #1 exp_q.delete();
        model_reset();
        @(negedge pixel_clk_in);
        chk("midclear_rst_we", int'(cell_we_out), 0);
        chk("midclear_rst_busy", int'(busy_out), 0);
        chk("midclear_rst_page_full", int'(page_full_out), 0);
        rst_in = 1'b0;
        repeat (3) @(negedge pixel_clk_in);
        chk("midclear_ready", int'(char_ready_out), 1);
        send_char("z", 0, w);

        apply_reset();
        for (int i = 0; i < 80; i++) begin
            send_char(rand_char(), 0, w);
            if (m_full) do_clear();
        end

        repeat (3) @(negedge pixel_clk_in);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
